pc_ctrl: RTL and testbench
==========================

Name: pc_ctrl

Overview:
Control end of the EX-stage redirect interface: consumes jump_en/jump_addr/hold_flag produced combinationally by the execute stage, owns the program counter, and generates pipeline flush/stall for the if_id and id_ex registers. Single clock domain, sits between the execute stage and the fetch path (pc register / instruction ROM address). Adds boot sequencing, jump accounting and a hold watchdog.

Parameters:
RESET_ADDR, 32'h0000_0000, PC value loaded on reset.
HOLD_MAX, 16, consecutive hold cycles that trigger the hold watchdog (>=1).

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst  input  1  reset, synchronous, active-high.
jump_en_i  input  1  redirect request from execute stage (combinational, same cycle).
jump_addr_i  input  32  redirect target, valid when jump_en_i=1.
hold_flag_i  input  1  stall request from execute stage.
pc_o  output  32  registered fetch address.
pc_valid_o  output  1  registered; pc_o is a valid fetch address.
flush_o  output  1  combinational; clear if_id and id_ex to NOP at next edge.
stall_o  output  1  combinational; freeze if_id and id_ex at next edge.
jump_cnt_o  output  32  registered count of accepted jumps, wraps.
misalign_o  output  1  registered one-cycle pulse: accepted target had addr[1:0]!=0.
hold_timeout_o  output  1  registered sticky watchdog flag.

Behaviour:
- Reset (rst=1 at posedge): pc_o=RESET_ADDR, pc_valid_o=0, jump_cnt_o=0, misalign_o=0, hold_timeout_o=0, hold counter=0, state=BOOT. While rst=1, flush_o=0, stall_o=0. Reset wins over every other input, including mid-hold and in REDIR.
- States: BOOT, RUN, REDIR.
- BOOT: exactly one cycle after reset release; flush_o=1, stall_o=0, pc_o held, pc_valid_o=0; jump_en_i/hold_flag_i ignored; next RUN, pc_valid_o becomes 1 and stays 1 until reset.
- RUN priority per cycle: accepted jump > hold > increment.
  - Jump (jump_en_i=1): flush_o=1, stall_o=0 same cycle; next pc_o={jump_addr_i[31:2],2'b00}; misalign_o=1 next cycle iff jump_addr_i[1:0]!=0; jump_cnt_o+1 (2^32-1 wraps to 0); hold counter cleared; next REDIR. hold_flag_i in the same cycle is ignored.
  - Hold (hold_flag_i=1, no jump): stall_o=1, flush_o=0, pc_o held; hold counter +1, saturating at HOLD_MAX; hold_timeout_o set at the edge closing the HOLD_MAX-th consecutive hold cycle, sticky until reset. Stay RUN.
  - Otherwise: pc_o+4 modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000); hold counter cleared; flush_o=0, stall_o=0.
- REDIR: exactly one cycle; jump_en_i ignored (EX holds the flushed bubble); hold and increment handled as in RUN; flush_o=0; next RUN.
- misalign_o is 0 in every cycle not directly following an accepted misaligned jump.
- Latency: redirect visible on pc_o one cycle after jump_en_i; flush and stall zero-cycle (combinational).
- No combinational path from pc_o state to jump_en_i inputs other than through flush_o/stall_o gating.

Test Plan:
1. rst=1 two cycles, release -> BOOT cycle: pc_o=0, pc_valid_o=0, flush_o=1; then pc_o 0x0,0x4,0x8,0xC with pc_valid_o=1, flush_o=0.
2. At pc_o=0x10, jump_en_i=1, jump_addr_i=0x100 for one cycle -> flush_o=1 that cycle; pc_o 0x100 then 0x104; jump_cnt_o=1; misalign_o=0.
3. jump_en_i held two cycles, addr 0x200 then 0x300 -> only first accepted: pc_o 0x200, 0x204; flush_o high one cycle only; jump_cnt_o +1.
4. At pc_o=0x20, hold_flag_i=1 for 3 cycles -> stall_o=1 for 3 cycles, pc_o stays 0x20, then 0x24; hold_timeout_o=0. Repeat with 16 consecutive cycles -> hold_timeout_o=1 after 16th edge, stays 1 after hold drops; rst clears it.
5. jump_en_i=1 and hold_flag_i=1 same cycle, jump_addr_i=0x102 -> stall_o=0, flush_o=1; pc_o=0x100; misalign_o=1 for exactly one cycle.
6. pc_o=0xFFFF_FFFC, no requests -> next pc_o=0x0; rst asserted during a 5-cycle hold -> next cycle pc_o=RESET_ADDR, pc_valid_o=0, stall_o=0, hold counter restarts from 0.

Source files
------------

// File: rtl/pc_ctrl.sv
// Program-counter owner for the fetch path: boot sequencing, EX-stage redirects,
// pipeline flush/stall generation, jump accounting and a hold watchdog.
module pc_ctrl #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned HOLD_MAX   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    output logic [31:0] pc_o,
    output logic        pc_valid_o,
    output logic        flush_o,
    output logic        stall_o,
    output logic [31:0] jump_cnt_o,
    output logic        misalign_o,
    output logic        hold_timeout_o
);

    localparam int unsigned    HCW        = $clog2(HOLD_MAX + 1);
    localparam logic [HCW-1:0] HOLD_MAX_C = HCW'(HOLD_MAX);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             valid_q;
    logic [31:0]      cnt_q, cnt_d;
    logic             mis_q, mis_d;
    logic             to_q, to_d;
    logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [HCW-1:0]   hold_inc_s;
    logic             jump_acc_s;
    logic             hold_s;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: BOOT and REDIR each last exactly one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:  state_d = ST_RUN;
            ST_RUN: begin
                if (jump_en_i) begin
                    state_d = ST_REDIR;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_REDIR: state_d = ST_RUN;
            default:  state_d = ST_BOOT;
        endcase
    end

    // Output decode; a jump in RUN masks any simultaneous hold request
    always_comb begin
        jump_acc_s = 1'b0;
        hold_s     = 1'b0;
        flush_o    = 1'b0;
        stall_o    = 1'b0;
        if (rst) begin
            flush_o = 1'b0;
            stall_o = 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: flush_o = 1'b1;
                ST_RUN: begin
                    if (jump_en_i) begin
                        jump_acc_s = 1'b1;
                        flush_o    = 1'b1;
                    end else begin
                        hold_s  = hold_flag_i;
                        stall_o = hold_flag_i;
                    end
                end
                ST_REDIR: begin
                    hold_s  = hold_flag_i;
                    stall_o = hold_flag_i;
                end
                default: begin
                    flush_o = 1'b0;
                    stall_o = 1'b0;
                end
            endcase
        end
    end

    // Datapath next-state: pc, jump counter, misalign pulse, hold watchdog
    always_comb begin
        hold_inc_s = (hold_cnt_q == HOLD_MAX_C) ? hold_cnt_q : hold_cnt_q + HCW'(1);
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        mis_d      = 1'b0;
        to_d       = to_q;
        hold_cnt_d = hold_cnt_q;
        if (jump_acc_s) begin
            pc_d       = {jump_addr_i[31:2], 2'b00};
            mis_d      = |jump_addr_i[1:0];
            cnt_d      = cnt_q + 32'd1;
            hold_cnt_d = '0;
        end else if (hold_s) begin
            hold_cnt_d = hold_inc_s;
            if (hold_inc_s == HOLD_MAX_C) begin
                to_d = 1'b1;
            end else begin
                to_d = to_q;
            end
        end else if (state_q != ST_BOOT) begin
            pc_d       = pc_q + 32'd4;
            hold_cnt_d = '0;
        end else begin
            pc_d = pc_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_ADDR;
            valid_q    <= 1'b0;
            cnt_q      <= 32'd0;
            mis_q      <= 1'b0;
            to_q       <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            valid_q    <= 1'b1;
            cnt_q      <= cnt_d;
            mis_q      <= mis_d;
            to_q       <= to_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign pc_o           = pc_q;
    assign pc_valid_o     = valid_q;
    assign jump_cnt_o     = cnt_q;
    assign misalign_o     = mis_q;
    assign hold_timeout_o = to_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed vector table, hand-written hold/reset
// sequences, then random traffic against a behavioural model.
module tb_pc_ctrl;

    localparam int HOLD_MAX = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_en_i = 1'b0;
    logic [31:0] jump_addr_i = 32'd0;
    logic        hold_flag_i = 1'b0;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        flush_o;
    logic        stall_o;
    logic [31:0] jump_cnt_o;
    logic        misalign_o;
    logic        hold_timeout_o;

    int n_tests = 0;
    int n_fail  = 0;

    pc_ctrl #(.RESET_ADDR(32'h0000_0000), .HOLD_MAX(HOLD_MAX)) dut (
        .clk           (clk),
        .rst           (rst),
        .jump_en_i     (jump_en_i),
        .jump_addr_i   (jump_addr_i),
        .hold_flag_i   (hold_flag_i),
        .pc_o          (pc_o),
        .pc_valid_o    (pc_valid_o),
        .flush_o       (flush_o),
        .stall_o       (stall_o),
        .jump_cnt_o    (jump_cnt_o),
        .misalign_o    (misalign_o),
        .hold_timeout_o(hold_timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        jen;
        logic [31:0] addr;
        logic        hold;
        logic        ef;
        logic        es;
        logic [31:0] epc;
        logic        ev;
        logic        em;
        logic        eto;
        logic [31:0] ecnt;
    } vec_t;

    vec_t vt[27];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check comb outputs before the edge and registered ones after
    task automatic cyc(input logic r, input logic jen, input logic [31:0] addr, input logic hold,
                       input logic ef, input logic es, input logic [31:0] epc, input logic ev,
                       input logic em, input logic eto, input logic [31:0] ecnt);
        @(negedge clk);
        rst = r; jump_en_i = jen; jump_addr_i = addr; hold_flag_i = hold;
        #1;
        chk("flush", {31'd0, flush_o}, {31'd0, ef});
        chk("stall", {31'd0, stall_o}, {31'd0, es});
        @(posedge clk);
        #1;
        chk("pc", pc_o, epc);
        chk("pc_valid", {31'd0, pc_valid_o}, {31'd0, ev});
        chk("misalign", {31'd0, misalign_o}, {31'd0, em});
        chk("timeout", {31'd0, hold_timeout_o}, {31'd0, eto});
        chk("jump_cnt", jump_cnt_o, ecnt);
    endtask

    // Behavioural model state
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_valid, m_mis, m_to, m_booting, m_after_jump;
    int          m_run;

    task automatic model_step(input logic r, input logic jen, input logic [31:0] addr, input logic hold);
        logic ef, es;
        ef = 1'b0; es = 1'b0;
        if (r) begin
            m_pc = 32'h0; m_valid = 1'b0; m_cnt = 32'd0; m_mis = 1'b0; m_to = 1'b0;
            m_run = 0; m_booting = 1'b1; m_after_jump = 1'b0;
        end else if (m_booting) begin
            ef = 1'b1; m_valid = 1'b1; m_booting = 1'b0; m_mis = 1'b0;
        end else if (jen && !m_after_jump) begin
            ef = 1'b1;
            m_pc = addr & ~32'd3;
            m_mis = (addr % 4) != 0;
            m_cnt = m_cnt + 1;
            m_run = 0;
            m_after_jump = 1'b1;
        end else if (hold) begin
            es = 1'b1; m_run++; m_mis = 1'b0; m_after_jump = 1'b0;
            if (m_run >= HOLD_MAX) m_to = 1'b1;
        end else begin
            m_pc = m_pc + 32'd4; m_run = 0; m_mis = 1'b0; m_after_jump = 1'b0;
        end
        cyc(r, jen, addr, hold, ef, es, m_pc, m_valid, m_mis, m_to, m_cnt);
    endtask

    initial begin
        //           rst   jen   addr          hold  flush stall pc_after     valid mis   to    cnt
        vt[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'd0};
        vt[1]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'd0};
        vt[2]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'd0};
        vt[3]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h4,        1'b1, 1'b0, 1'b0, 32'd0};
        vt[4]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h8,        1'b1, 1'b0, 1'b0, 32'd0};
        vt[5]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'hC,        1'b1, 1'b0, 1'b0, 32'd0};
        vt[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h10,       1'b1, 1'b0, 1'b0, 32'd0};
        vt[7]  = '{1'b0, 1'b1, 32'h100,      1'b0, 1'b1, 1'b0, 32'h100,      1'b1, 1'b0, 1'b0, 32'd1};
        vt[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h104,      1'b1, 1'b0, 1'b0, 32'd1};
        vt[9]  = '{1'b0, 1'b1, 32'h200,      1'b0, 1'b1, 1'b0, 32'h200,      1'b1, 1'b0, 1'b0, 32'd2};
        vt[10] = '{1'b0, 1'b1, 32'h300,      1'b0, 1'b0, 1'b0, 32'h204,      1'b1, 1'b0, 1'b0, 32'd2};
        vt[11] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h208,      1'b1, 1'b0, 1'b0, 32'd2};
        vt[12] = '{1'b0, 1'b1, 32'h20,       1'b0, 1'b1, 1'b0, 32'h20,       1'b1, 1'b0, 1'b0, 32'd3};
        vt[13] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h20,       1'b1, 1'b0, 1'b0, 32'd3};
        vt[14] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h20,       1'b1, 1'b0, 1'b0, 32'd3};
        vt[15] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h20,       1'b1, 1'b0, 1'b0, 32'd3};
        vt[16] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h24,       1'b1, 1'b0, 1'b0, 32'd3};
        vt[17] = '{1'b0, 1'b1, 32'h102,      1'b1, 1'b1, 1'b0, 32'h100,      1'b1, 1'b1, 1'b0, 32'd4};
        vt[18] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h104,      1'b1, 1'b0, 1'b0, 32'd4};
        vt[19] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'd5};
        vt[20] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'd5};
        vt[21] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h4,        1'b1, 1'b0, 1'b0, 32'd5};
        vt[22] = '{1'b0, 1'b1, 32'h3,        1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'd6};
        vt[23] = '{1'b0, 1'b1, 32'h2,        1'b0, 1'b0, 1'b0, 32'h4,        1'b1, 1'b0, 1'b0, 32'd6};
        vt[24] = '{1'b1, 1'b1, 32'h40,       1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'd0};
        vt[25] = '{1'b0, 1'b1, 32'h500,      1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'd0};
        vt[26] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h4,        1'b1, 1'b0, 1'b0, 32'd0};

        for (int i = 0; i < 27; i++) begin
            cyc(vt[i].rst, vt[i].jen, vt[i].addr, vt[i].hold, vt[i].ef, vt[i].es,
                vt[i].epc, vt[i].ev, vt[i].em, vt[i].eto, vt[i].ecnt);
        end

        // Watchdog: 15 holds stay quiet, the 16th sets the sticky flag
        for (int i = 1; i <= HOLD_MAX; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h4, 1'b1, 1'b0, (i == HOLD_MAX), 32'd0);
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h8, 1'b1, 1'b0, 1'b1, 32'd0);

        // Reset in the middle of a 5-cycle hold
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h8, 1'b1, 1'b0, 1'b1, 32'd0);
        end
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'd0);
        // Hold counter must restart from zero after reset
        for (int i = 1; i <= HOLD_MAX; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, (i == HOLD_MAX), 32'd0);
        end

        // Broken hold streak: 15 + idle + 15 must not trip the watchdog
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < HOLD_MAX - 1; i++)
            cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h4, 1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < HOLD_MAX - 1; i++)
            cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 32'd0);

        // Random traffic against the model, alternating light and heavy hold phases
        model_step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 1500; i++) begin
            logic r, j, h;
            logic [31:0] a;
            r = ($urandom_range(0, 79) == 0);
            j = ($urandom_range(0, 5) == 0);
            if (((i / 60) % 2) == 1) h = ($urandom_range(0, 19) != 0);
            else                     h = ($urandom_range(0, 2) == 0);
            a = $urandom;
            model_step(r, j, a, h);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
